// File: rtl/mux_rr_stream.sv
// N-channel registered stream mux with fixed-select or round-robin arbitration.
// Latency: 1 cycle from accept to out_data. Backpressure: in_ready is 0 while the held word stalls.
module mux_rr_stream #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [CW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_chan
);

  logic [CW-1:0] last;
  logic [CW-1:0] gidx;
  logic [N-1:0]  grant;
  logic [W-1:0]  gword;
  logic          load;
  logic          xfer;
  int            best;

  // Round-robin: each channel's distance past the last winner; the nearest valid one wins.
  always_comb begin : arbiter
    grant = '0;
    best  = N;
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && (((i - int'(last) - 1 + 2 * N) % N) < best)) begin
          best = (i - int'(last) - 1 + 2 * N) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        grant[i] = in_valid[i] && (((i - int'(last) - 1 + 2 * N) % N) == best);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        grant[i] = in_valid[i] && (sel == CW'(i));
      end
    end
  end

  always_comb begin : grant_mux
    gidx  = '0;
    gword = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx  = CW'(i);
        gword = in_data[i*W +: W];
      end
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = rst_n ? (grant & {N{load}}) : '0;
  assign xfer     = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= CW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gword;
      out_chan  <= gidx;
      if (mode) begin
        last <= gidx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream (N=4, W=8): directed scenarios plus a randomized run against a reference model.
module tb_mux_rr_stream;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  int checks;
  int failures;

  mux_rr_stream #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    tick(); tick();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++;
    rst_n = 1'b1;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(8'h11, 8'h22, 8'hAB, 8'h44);
    tick();
    if (out_data !== 8'hAB) begin failures++; $display("FAIL rst_preload got=%h exp=ab", out_data); end
    checks++;
    // asynchronous assertion between edges with a word held
    #2;
    rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin failures++; $display("FAIL rst_async_data got=%h exp=00", out_data); end
    checks++;
    if (out_chan !== 2'd0) begin failures++; $display("FAIL rst_async_chan got=%0d exp=0", out_chan); end
    checks++;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL rst_async_ready got=%b exp=0000", in_ready); end
    checks++;
    tick();
    rst_n = 1'b1;
    in_valid = 4'b0000;
    #1;
  endtask

  task automatic test_fixed_select();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(8'h10, 8'h20, 8'hAB, 8'h40);
    #1;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL fs_ready got=%b exp=0100", in_ready); end
    checks++;
    tick();
    if (out_data !== 8'hAB || out_chan !== 2'd2 || out_valid !== 1'b1) begin
      failures++; $display("FAIL fs_out got=%h/%0d/%b exp=ab/2/1", out_data, out_chan, out_valid);
    end
    checks++;
    sel = 2'd1;
    set_data(8'h10, 8'h08, 8'hAB, 8'h40);
    #1;
    if (in_ready !== 4'b0010) begin failures++; $display("FAIL fs_ready2 got=%b exp=0010", in_ready); end
    checks++;
    tick();
    if (out_data !== 8'h08 || out_chan !== 2'd1) begin
      failures++; $display("FAIL fs_out2 got=%h/%0d exp=08/1", out_data, out_chan);
    end
    checks++;
    // selected channel idle: other valid channels must not be granted
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL fs_noother got=%b exp=0000", in_ready); end
    checks++;
    tick();
    if (out_valid !== 1'b0 || out_data !== 8'h08 || out_chan !== 2'd1) begin
      failures++; $display("FAIL fs_drain got=%b/%h/%0d exp=0/08/1", out_valid, out_data, out_chan);
    end
    checks++;
  endtask

  task automatic test_round_robin();
    logic [7:0] rr [4];
    rr[0] = 8'hF2; rr[1] = 8'h90; rr[2] = 8'hCC; rr[3] = 8'h54;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(rr[0], rr[1], rr[2], rr[3]);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_chan !== 2'(k % 4) || out_data !== rr[k % 4] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_step%0d got=%0d/%h/%b exp=%0d/%h/1", k, out_chan, out_data, out_valid, k % 4, rr[k % 4]);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    set_data(8'hF2, 8'h67, 8'hCC, 8'h54);
    tick();
    if (out_data !== 8'h67 || out_chan !== 2'd1) begin
      failures++; $display("FAIL bp_load got=%h/%0d exp=67/1", out_data, out_chan);
    end
    checks++;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0000", k, in_ready); end
      checks++;
      tick();
      if (out_data !== 8'h67 || out_chan !== 2'd1 || out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold%0d got=%h/%0d/%b exp=67/1/1", k, out_data, out_chan, out_valid);
      end
      checks++;
    end
    set_data(8'hF2, 8'h67, 8'h11, 8'h54);
    out_ready = 1'b1;
    #1;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL bp_nobubble_ready got=%b exp=0100", in_ready); end
    checks++;
    tick();
    if (out_data !== 8'h11 || out_chan !== 2'd2 || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_nobubble got=%h/%0d/%b exp=11/2/1", out_data, out_chan, out_valid);
    end
    checks++;
  endtask

  task automatic test_sparse_empty();
    in_valid = 4'b1000;
    tick();
    if (out_chan !== 2'd3) begin failures++; $display("FAIL sp_prime got=%0d exp=3", out_chan); end
    checks++;
    in_valid = 4'b1010;
    #1;
    if (in_ready !== 4'b0010) begin failures++; $display("FAIL sp_grant1 got=%b exp=0010", in_ready); end
    checks++;
    tick();
    if (out_chan !== 2'd1 || out_data !== 8'h67) begin
      failures++; $display("FAIL sp_out1 got=%0d/%h exp=1/67", out_chan, out_data);
    end
    checks++;
    if (in_ready !== 4'b1000) begin failures++; $display("FAIL sp_grant3 got=%b exp=1000", in_ready); end
    checks++;
    tick();
    if (out_chan !== 2'd3 || out_data !== 8'h54) begin
      failures++; $display("FAIL sp_out3 got=%0d/%h exp=3/54", out_chan, out_data);
    end
    checks++;
    in_valid = 4'b0000;
    #1;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL sp_empty_ready got=%b exp=0000", in_ready); end
    checks++;
    tick();
    if (out_valid !== 1'b0 || out_chan !== 2'd3 || out_data !== 8'h54) begin
      failures++; $display("FAIL sp_drain got=%b/%0d/%h exp=0/3/54", out_valid, out_chan, out_data);
    end
    checks++;
  endtask

  task automatic test_mode_switch();
    mode = 1'b1; in_valid = 4'b1111;
    set_data(8'hF2, 8'h90, 8'hCC, 8'h54);
    tick();
    if (out_chan !== 2'd0) begin failures++; $display("FAIL ms_rr got=%0d exp=0", out_chan); end
    checks++;
    mode = 1'b0; sel = 2'd3;
    tick(); tick();
    if (out_chan !== 2'd3 || out_data !== 8'h54) begin
      failures++; $display("FAIL ms_fixed got=%0d/%h exp=3/54", out_chan, out_data);
    end
    checks++;
    mode = 1'b1;
    set_data(8'hF2, 8'hFF, 8'hCC, 8'h54);
    #1;
    if (in_ready !== 4'b0010) begin failures++; $display("FAIL ms_resume got=%b exp=0010", in_ready); end
    checks++;
    tick();
    if (out_chan !== 2'd1 || out_data !== 8'hFF) begin
      failures++; $display("FAIL ms_ones got=%0d/%h exp=1/ff", out_chan, out_data);
    end
    checks++;
    set_data(8'hF2, 8'hFF, 8'h00, 8'h54);
    tick();
    if (out_chan !== 2'd2 || out_data !== 8'h00 || out_valid !== 1'b1) begin
      failures++; $display("FAIL ms_zeros got=%0d/%h/%b exp=2/00/1", out_chan, out_data, out_valid);
    end
    checks++;
  endtask

  task automatic test_random();
    int         g;
    int         m_last;
    logic       m_v;
    logic [7:0] m_d;
    int         m_c;
    logic [3:0] exp_rdy;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_last = 3; m_v = 1'b0; m_d = 8'h00; m_c = 0;
    for (int n = 0; n < 500; n++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (!mode) begin
        if (in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 1; k <= 4; k++) begin
          if (g < 0 && in_valid[(m_last + k) % 4]) g = (m_last + k) % 4;
        end
      end
      exp_rdy = (g >= 0 && (!m_v || out_ready)) ? 4'(1 << g) : 4'b0000;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL rnd_ready%0d got=%b exp=%b", n, in_ready, exp_rdy);
      end
      checks++;
      if (exp_rdy != 4'b0000) begin
        m_v = 1'b1; m_d = in_data[g*8 +: 8]; m_c = g;
        if (mode) m_last = g;
      end else if (out_ready) begin
        m_v = 1'b0;
      end
      tick();
      if (out_valid !== m_v || out_data !== m_d || out_chan !== 2'(m_c)) begin
        failures++;
        $display("FAIL rnd_out%0d got=%b/%h/%0d exp=%b/%h/%0d", n, out_valid, out_data, out_chan, m_v, m_d, m_c);
      end
      checks++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_backpressure();
    test_sparse_empty();
    test_mode_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
